// File: rtl/robot_motion_scheduler.sv
// Motion scheduler for the shared left/right motor drive: accepts one move at a time,
// ramps the PWM duty up, holds it for the commanded ticks, then ramps it back down.
module robot_motion_scheduler #(
  parameter int DUR_W     = 8,
  parameter int DUTY_W    = 8,
  parameter int TICK_DIV  = 16,
  parameter int RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_dir,
  input  logic [DUTY_W-1:0] cmd_speed,
  input  logic [DUR_W-1:0]  cmd_dur,
  input  logic              obstacle,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty,
  output logic              motor_l_dir,
  output logic              motor_r_dir,
  output logic              busy,
  output logic              done_pulse,
  output logic              aborted,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    HALT      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'b00,
    DIR_REV   = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W:0]   STEP_EXT  = (DUTY_W + 1)'(RAMP_STEP);

  state_t              state, state_nxt;
  dir_t                dir_q;
  logic [DUTY_W-1:0]   speed_q;
  logic [DUR_W-1:0]    run_cnt;
  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  logic                accept;
  logic                zero_cmd;
  logic                obstacle_hit;
  logic [DUTY_W:0]     up_sum;
  logic                up_done;
  logic                down_done;

  assign tick         = (tick_cnt == TICK_LAST);
  assign accept       = cmd_valid && cmd_ready;
  assign zero_cmd     = (cmd_speed == '0) || (cmd_dur == '0);
  assign obstacle_hit = obstacle && (dir_q == DIR_FWD) && ((state == RAMP_UP) || (state == RUN));
  // Ramp arithmetic carries one extra bit so a step near full scale cannot wrap.
  assign up_sum       = {1'b0, duty} + STEP_EXT;
  assign up_done      = (up_sum >= {1'b0, speed_q});
  assign down_done    = ({1'b0, duty} <= STEP_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block purely combinational;
  // without it, any branch that skips state_nxt would infer a latch.
  always_comb begin
    state_nxt = state;
    if (estop) begin
      state_nxt = HALT;
    end else begin
      unique case (state)
        IDLE:      if (accept && !zero_cmd) state_nxt = RAMP_UP;
        RAMP_UP: begin
          if (obstacle_hit)          state_nxt = RAMP_DOWN;
          else if (tick && up_done)  state_nxt = RUN;
        end
        RUN: begin
          if (obstacle_hit)                          state_nxt = RAMP_DOWN;
          else if (tick && (run_cnt == DUR_W'(1)))   state_nxt = RAMP_DOWN;
        end
        RAMP_DOWN: if (tick && down_done) state_nxt = IDLE;
        HALT:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty        <= '0;
      motor_l_dir <= 1'b0;
      motor_r_dir <= 1'b0;
      dir_q       <= DIR_FWD;
      speed_q     <= '0;
      run_cnt     <= '0;
      done_pulse  <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (estop) begin
        duty <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              dir_q   <= dir_t'(cmd_dir);
              speed_q <= cmd_speed;
              run_cnt <= cmd_dur;
              aborted <= 1'b0;
              unique case (dir_t'(cmd_dir))
                DIR_FWD:   {motor_l_dir, motor_r_dir} <= 2'b11;
                DIR_REV:   {motor_l_dir, motor_r_dir} <= 2'b00;
                DIR_LEFT:  {motor_l_dir, motor_r_dir} <= 2'b01;
                DIR_RIGHT: {motor_l_dir, motor_r_dir} <= 2'b10;
                default:   {motor_l_dir, motor_r_dir} <= 2'b00;
              endcase
              if (zero_cmd) done_pulse <= 1'b1;
            end
          end
          RAMP_UP: begin
            if (obstacle_hit)  aborted <= 1'b1;
            else if (tick)     duty <= up_done ? speed_q : up_sum[DUTY_W-1:0];
          end
          RUN: begin
            if (obstacle_hit)  aborted <= 1'b1;
            else if (tick)     run_cnt <= run_cnt - DUR_W'(1);
          end
          RAMP_DOWN: begin
            if (tick) begin
              if (down_done) begin
                duty       <= '0;
                done_pulse <= 1'b1;
              end else begin
                duty <= duty - STEP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !estop;
    busy      = (state != IDLE);
    state_o   = state;
  end

endmodule

// File: tb/tb_robot_motion_scheduler.sv
// Directed bench for robot_motion_scheduler with TICK_DIV=4, RAMP_STEP=16:
// move profiles, obstacle abort, estop, zero-length commands and reset.
module tb_robot_motion_scheduler;
  localparam int DUR_W = 8, DUTY_W = 8, TICK_DIV = 4, RAMP_STEP = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_dir = 2'b00;
  logic [DUTY_W-1:0] cmd_speed = '0;
  logic [DUR_W-1:0]  cmd_dur = '0;
  logic              obstacle = 1'b0;
  logic              estop = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic              motor_l_dir, motor_r_dir, busy, done_pulse, aborted;
  logic [2:0]        state_o;

  int checks = 0;
  int errors = 0;

  int s_duty[$], s_state[$], s_l[$], s_r[$], s_ab[$];
  int ch_val[$], ch_idx[$];
  int exp_v[$], exp_g[$];

  robot_motion_scheduler #(
    .DUR_W(DUR_W), .DUTY_W(DUTY_W), .TICK_DIV(TICK_DIV), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_speed(cmd_speed), .cmd_dur(cmd_dur),
    .obstacle(obstacle), .estop(estop), .duty(duty),
    .motor_l_dir(motor_l_dir), .motor_r_dir(motor_r_dir), .busy(busy),
    .done_pulse(done_pulse), .aborted(aborted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Called on a falling edge; presents a command for one rising edge.
  task automatic issue(input string name, input logic [1:0] dir, input int speed, input int dur);
    cmd_dir = dir; cmd_speed = DUTY_W'(speed); cmd_dur = DUR_W'(dur); cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: cmd_ready=%b expected 1", name, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Samples every falling edge until done_pulse, then extracts the duty change list.
  task automatic record(input string name, input int max_cyc);
    bit seen = 0;
    s_duty.delete(); s_state.delete(); s_l.delete(); s_r.delete(); s_ab.delete();
    for (int i = 0; i < max_cyc; i++) begin
      s_duty.push_back(int'(duty)); s_state.push_back(int'(state_o));
      s_l.push_back(int'(motor_l_dir)); s_r.push_back(int'(motor_r_dir)); s_ab.push_back(int'(aborted));
      if (done_pulse === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout: no done_pulse within %0d cycles", name, max_cyc); end
    ch_val.delete(); ch_idx.delete();
    for (int i = 1; i < s_duty.size(); i++)
      if (s_duty[i] != s_duty[i-1]) begin ch_val.push_back(s_duty[i]); ch_idx.push_back(i); end
  endtask

  // Waits (bounded) for state_o (sel=0) or duty (sel=1) to reach a value.
  task automatic wait_for(input string name, input int sel, input int value, input int max_cyc);
    bit hit = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if ((sel == 0 && int'(state_o) == value) || (sel == 1 && int'(duty) == value)) begin hit = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL %s_wait: value %0d not reached within %0d cycles", name, value, max_cyc); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_speed = 8'd99; cmd_dur = 8'd9; cmd_dir = 2'b10;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (duty !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if ({motor_l_dir, motor_r_dir} !== 2'b00) begin errors++; $display("FAIL reset_dir: got %b expected 00", {motor_l_dir, motor_r_dir}); end
    checks++; if ({done_pulse, aborted, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: done/aborted/busy=%b expected 000", {done_pulse, aborted, busy}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_fwd_move();
    int run_cyc = 0;
    rst = 1'b0;
    issue("fwd", 2'b00, 40, 3);
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fwd_ready_after: ready=%b busy=%b expected 0/1", cmd_ready, busy); end
    record("fwd", 80);
    exp_v = '{16, 32, 40, 24, 8, 0};
    exp_g = '{3, 4, 4, 16, 4, 4};
    checks++;
    if (ch_val.size() != exp_v.size()) begin errors++; $display("FAIL fwd_steps: got %0d duty changes expected %0d", ch_val.size(), exp_v.size()); end
    else foreach (exp_v[i]) begin
      checks++;
      if (ch_val[i] != exp_v[i]) begin errors++; $display("FAIL fwd_duty[%0d]: got %0d expected %0d", i, ch_val[i], exp_v[i]); end
      checks++;
      if (ch_idx[i] - ((i == 0) ? 0 : ch_idx[i-1]) != exp_g[i]) begin errors++; $display("FAIL fwd_gap[%0d]: got %0d cycles expected %0d", i, ch_idx[i] - ((i == 0) ? 0 : ch_idx[i-1]), exp_g[i]); end
    end
    foreach (s_state[i]) if (s_state[i] == 2) run_cyc++;
    checks++; if (run_cyc != 12) begin errors++; $display("FAIL fwd_run_len: got %0d cycles expected 12", run_cyc); end
    checks++; if (s_l.sum() != s_l.size() || s_r.sum() != s_r.size() || s_ab.sum() != 0) begin errors++; $display("FAIL fwd_dir_abort: l=%0d r=%0d ab=%0d of %0d samples expected all 1,1,0", s_l.sum(), s_r.sum(), s_ab.sum(), s_l.size()); end
    @(negedge clk);
    checks++; if (done_pulse !== 1'b0 || state_o !== 3'd0) begin errors++; $display("FAIL fwd_done_width: done=%b state=%0d expected 0/0", done_pulse, state_o); end
  endtask

  task automatic test_left_saturate();
    int run_cyc = 0;
    issue("left", 2'b10, 200, 1);
    record("left", 200);
    exp_v.delete();
    for (int k = 1; k <= 12; k++) exp_v.push_back(16 * k);
    exp_v.push_back(200);
    for (int k = 1; k <= 12; k++) exp_v.push_back(200 - 16 * k);
    exp_v.push_back(0);
    checks++;
    if (ch_val.size() != exp_v.size()) begin errors++; $display("FAIL left_steps: got %0d duty changes expected %0d", ch_val.size(), exp_v.size()); end
    else foreach (exp_v[i]) begin
      checks++;
      if (ch_val[i] != exp_v[i]) begin errors++; $display("FAIL left_duty[%0d]: got %0d expected %0d", i, ch_val[i], exp_v[i]); end
      if (i > 0) begin
        checks++;
        if (ch_idx[i] - ch_idx[i-1] != ((i == 13) ? 8 : 4)) begin errors++; $display("FAIL left_gap[%0d]: got %0d expected %0d", i, ch_idx[i] - ch_idx[i-1], (i == 13) ? 8 : 4); end
      end
    end
    foreach (s_state[i]) if (s_state[i] == 2) run_cyc++;
    checks++; if (run_cyc != 4) begin errors++; $display("FAIL left_run_len: got %0d cycles expected 4", run_cyc); end
    checks++; if (s_l.sum() != 0 || s_r.sum() != s_r.size()) begin errors++; $display("FAIL left_dir: l=%0d r=%0d of %0d samples expected l=0 r=all", s_l.sum(), s_r.sum(), s_r.size()); end
    @(negedge clk);
  endtask

  task automatic test_obstacle();
    int run_cyc = 0;
    issue("obst_fwd", 2'b00, 64, 10);
    wait_for("obst_run", 0, 2, 60);
    @(negedge clk);
    obstacle = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== 3'd3 || aborted !== 1'b1 || duty !== 8'd64) begin errors++; $display("FAIL obst_entry: state=%0d aborted=%b duty=%0d expected 3/1/64", state_o, aborted, duty); end
    record("obst_down", 40);
    exp_v = '{48, 32, 16, 0};
    checks++;
    if (ch_val.size() != exp_v.size()) begin errors++; $display("FAIL obst_steps: got %0d duty changes expected %0d", ch_val.size(), exp_v.size()); end
    else foreach (exp_v[i]) begin
      checks++;
      if (ch_val[i] != exp_v[i]) begin errors++; $display("FAIL obst_duty[%0d]: got %0d expected %0d", i, ch_val[i], exp_v[i]); end
    end
    repeat (2) @(negedge clk);
    checks++; if (aborted !== 1'b1 || done_pulse !== 1'b0) begin errors++; $display("FAIL obst_sticky: aborted=%b done=%b expected 1/0", aborted, done_pulse); end
    // Obstacle stays asserted: a reverse move must ignore it and run to completion.
    issue("obst_rev", 2'b01, 64, 10);
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL rev_abort_clear: got %b expected 0", aborted); end
    record("rev", 120);
    exp_v = '{16, 32, 48, 64, 48, 32, 16, 0};
    checks++;
    if (ch_val.size() != exp_v.size()) begin errors++; $display("FAIL rev_steps: got %0d duty changes expected %0d", ch_val.size(), exp_v.size()); end
    else foreach (exp_v[i]) begin
      checks++;
      if (ch_val[i] != exp_v[i]) begin errors++; $display("FAIL rev_duty[%0d]: got %0d expected %0d", i, ch_val[i], exp_v[i]); end
      if (i > 0) begin
        checks++;
        if (ch_idx[i] - ch_idx[i-1] != ((i == 4) ? 44 : 4)) begin errors++; $display("FAIL rev_gap[%0d]: got %0d expected %0d", i, ch_idx[i] - ch_idx[i-1], (i == 4) ? 44 : 4); end
      end
    end
    foreach (s_state[i]) if (s_state[i] == 2) run_cyc++;
    checks++; if (run_cyc != 40 || s_ab.sum() != 0) begin errors++; $display("FAIL rev_run: run=%0d aborted_samples=%0d expected 40/0", run_cyc, s_ab.sum()); end
    checks++; if (s_l.sum() != 0 || s_r.sum() != 0) begin errors++; $display("FAIL rev_dir: l=%0d r=%0d expected 0/0", s_l.sum(), s_r.sum()); end
    obstacle = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_estop();
    issue("estop_fwd", 2'b00, 200, 5);
    wait_for("estop_ramp", 1, 32, 40);
    estop = 1'b1;
    cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_speed = 8'd32; cmd_dur = 8'd1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL estop_ready_comb: got %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++; if (duty !== 8'd0 || state_o !== 3'd4 || done_pulse !== 1'b0) begin errors++; $display("FAIL estop_halt: duty=%0d state=%0d done=%b expected 0/4/0", duty, state_o, done_pulse); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL estop_ready: ready=%b busy=%b expected 0/1", cmd_ready, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state_o !== 3'd4 || done_pulse !== 1'b0 || duty !== 8'd0 || {motor_l_dir, motor_r_dir} !== 2'b11) begin
        errors++; $display("FAIL estop_hold[%0d]: state=%0d done=%b duty=%0d dir=%b expected 4/0/0/11", i, state_o, done_pulse, duty, {motor_l_dir, motor_r_dir});
      end
    end
    estop = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL estop_release_ready: got %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++; if (state_o !== 3'd0 || cmd_ready !== 1'b1 || {motor_l_dir, motor_r_dir} !== 2'b11) begin errors++; $display("FAIL estop_idle: state=%0d ready=%b dir=%b expected 0/1/11", state_o, cmd_ready, {motor_l_dir, motor_r_dir}); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (state_o !== 3'd1 || {motor_l_dir, motor_r_dir} !== 2'b00) begin errors++; $display("FAIL estop_accept: state=%0d dir=%b expected 1/00", state_o, {motor_l_dir, motor_r_dir}); end
    record("estop_cmd", 60);
    checks++; if (ch_val.size() != 4) begin errors++; $display("FAIL estop_cmd_steps: got %0d duty changes expected 4", ch_val.size()); end
    @(negedge clk);
  endtask

  task automatic test_zero_cmd();
    issue("zero_speed", 2'b00, 0, 5);
    checks++; if (state_o !== 3'd0 || done_pulse !== 1'b1 || duty !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL zero_speed: state=%0d done=%b duty=%0d busy=%b expected 0/1/0/0", state_o, done_pulse, duty, busy); end
    @(negedge clk);
    checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL zero_speed_pulse: got %b expected 0", done_pulse); end
    issue("zero_dur", 2'b01, 50, 0);
    checks++; if (state_o !== 3'd0 || done_pulse !== 1'b1 || duty !== 8'd0 || {motor_l_dir, motor_r_dir} !== 2'b00) begin errors++; $display("FAIL zero_dur: state=%0d done=%b duty=%0d dir=%b expected 0/1/0/00", state_o, done_pulse, duty, {motor_l_dir, motor_r_dir}); end
    @(negedge clk);
    checks++; if (done_pulse !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_dur_pulse: done=%b ready=%b expected 0/1", done_pulse, cmd_ready); end
  endtask

  task automatic test_reset_mid_run();
    issue("rst_fwd", 2'b00, 40, 10);
    wait_for("rst_run", 1, 40, 40);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (duty !== 8'd0 || state_o !== 3'd0 || {motor_l_dir, motor_r_dir} !== 2'b00) begin errors++; $display("FAIL rst_mid: duty=%0d state=%0d dir=%b expected 0/0/00", duty, state_o, {motor_l_dir, motor_r_dir}); end
    checks++; if (aborted !== 1'b0 || done_pulse !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: aborted=%b done=%b expected 0/0", aborted, done_pulse); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b expected 0", done_pulse); end
    issue("both_fwd", 2'b00, 64, 10);
    wait_for("both_run", 0, 2, 60);
    obstacle = 1'b1; estop = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== 3'd4 || aborted !== 1'b0 || duty !== 8'd0 || done_pulse !== 1'b0) begin errors++; $display("FAIL estop_over_obst: state=%0d aborted=%b duty=%0d done=%b expected 4/0/0/0", state_o, aborted, duty, done_pulse); end
    obstacle = 1'b0; estop = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL both_release: state=%0d expected 0", state_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fwd_move();
    test_left_saturate();
    test_obstacle();
    test_estop();
    test_zero_cmd();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
